// File: rtl/seg7_pkg.sv
// Shared types and constants for the seg7_scan_ctrl multiplexed display controller.
// The display word struct is sized for the largest supported display (8 digits).
package seg7_pkg;

   localparam int MAX_DIGITS = 8;
   localparam logic [6:0] SEG_OFF = 7'h7F;

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } state_e;

   typedef struct packed {
      logic [4*MAX_DIGITS-1:0] value;
      logic [MAX_DIGITS-1:0]   dp;
      logic [MAX_DIGITS-1:0]   en;
   } disp_word_t;

   // All anodes of an n-digit display switched off (active-low, so all ones).
   function automatic logic [MAX_DIGITS-1:0] anode_off(input int n);
      logic [MAX_DIGITS-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (i < n) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex7seg.sv
// hex7seg: hex nibble to active-low 7-segment pattern, bit 0 = segment a.
// Purely combinational; the scan controller registers its output.
module hex7seg (
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = 7'h7F;
      unique case (hex_i)
         4'h0: seg_o = 7'h40;
         4'h1: seg_o = 7'h79;
         4'h2: seg_o = 7'h24;
         4'h3: seg_o = 7'h30;
         4'h4: seg_o = 7'h19;
         4'h5: seg_o = 7'h12;
         4'h6: seg_o = 7'h02;
         4'h7: seg_o = 7'h78;
         4'h8: seg_o = 7'h00;
         4'h9: seg_o = 7'h10;
         4'hA: seg_o = 7'h08;
         4'hB: seg_o = 7'h03;
         4'hC: seg_o = 7'h46;
         4'hD: seg_o = 7'h21;
         4'hE: seg_o = 7'h06;
         4'hF: seg_o = 7'h0E;
         default: seg_o = 7'h7F;
      endcase
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Common-anode 7-segment scan controller with a double-buffered display word.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    load,
   output logic                    load_ack,
   output logic                    frame_start,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output state_e                  dbg_state
);

   localparam int DIV_W = $clog2(REFRESH_DIV);
   localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [DIV_W-1:0] LAST_DIV   = DIV_W'(REFRESH_DIV - 1);
   localparam logic [DIV_W-1:0] BLANK_LAST = DIV_W'(BLANK_CYCLES - 1);
   localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_OFF = NUM_DIGITS'(anode_off(NUM_DIGITS));
   localparam disp_word_t RESET_WORD = '{value: '0, dp: '0, en: '1};

   state_e              state_q, state_d;
   logic [DIG_W-1:0]    digit_q, digit_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic                run_q;
   disp_word_t          active_q, active_d, pend_q, pend_d, load_word;
   logic                pend_valid_q, pend_valid_d;
   logic                boundary;
   logic [3:0]          nibble;
   logic [6:0]          dec_seg;
   logic [NUM_DIGITS-1:0] lz_dark, shown;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d, ack_q, ack_d, fs_q, fs_d;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
   logic                nz;
`endif

   // run_q spends the first cycle after reset release arming the scan, so the
   // registered frame_start lines up with the first digit-0 blank cycle.
   always_comb begin
      state_d  = state_q;
      digit_d  = digit_q;
      div_d    = div_q;
      boundary = 1'b0;
      if (run_q) begin
         div_d = (div_q == LAST_DIV) ? '0 : div_q + DIV_W'(1);
         unique case (state_q)
            BLANK: if (div_q == BLANK_LAST) state_d = DRIVE;
            DRIVE: begin
               if (div_q == LAST_DIV) begin
                  state_d = BLANK;
                  if (digit_q == LAST_DIGIT) begin
                     digit_d  = '0;
                     boundary = 1'b1;
                  end else begin
                     digit_d = digit_q + DIG_W'(1);
                  end
               end
            end
            default: state_d = BLANK;
         endcase
      end
   end

   // load is a valid-only strobe with no backpressure: every pulse is accepted,
   // the latest one wins, and load_ack marks the pending word going active.
   always_comb begin
      load_word = '0;
      load_word.value[4*NUM_DIGITS-1:0] = value_in;
      load_word.dp[NUM_DIGITS-1:0]      = dp_in;
      load_word.en[NUM_DIGITS-1:0]      = digit_en;
      active_d     = active_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      ack_d        = 1'b0;
      if (boundary && pend_valid_q) begin
         active_d     = pend_q;
         pend_valid_d = 1'b0;
         ack_d        = 1'b1;
      end
      if (load) begin
         pend_d       = load_word;
         pend_valid_d = 1'b1;
      end
   end

   always_comb begin
      lz_dark = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      nz = 1'b0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         nz = nz | (active_d.value[4*k +: 4] != 4'h0);
         lz_dark[k] = (k != 0) && !nz;
      end
`endif
   end

   assign shown  = active_d.en[NUM_DIGITS-1:0] & ~lz_dark;
   assign nibble = active_d.value[4*digit_d +: 4];

   hex7seg u_hex7seg (
      .hex_i (nibble),
      .seg_o (dec_seg)
   );

   // Outputs are computed from next-state values so the registers change on
   // the same edge as state, digit and div.
   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      fs_d  = !run_q || boundary;
      if (state_d == DRIVE) begin
         if (shown[digit_d]) an_d[digit_d] = 1'b0;
         seg_d = dec_seg;
         dp_d  = !(active_d.dp[digit_d] && !lz_dark[digit_d]);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run_q        <= 1'b0;
         state_q      <= BLANK;
         digit_q      <= '0;
         div_q        <= '0;
         active_q     <= RESET_WORD;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         an_q         <= AN_OFF;
         seg_q        <= SEG_OFF;
         dp_q         <= 1'b1;
         ack_q        <= 1'b0;
         fs_q         <= 1'b0;
      end else begin
         run_q        <= 1'b1;
         state_q      <= state_d;
         digit_q      <= digit_d;
         div_q        <= div_d;
         active_q     <= active_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         ack_q        <= ack_d;
         fs_q         <= fs_d;
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign dp          = dp_q;
   assign load_ack    = ack_q;
   assign frame_start = fs_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl (4 digits, 8-cycle slots, 2 blank cycles); honours
// SEG7_LEADING_ZERO_BLANK_EN the same way the design does.
module tb_seg7_scan_ctrl;

   localparam int N     = 4;
   localparam int RD    = 8;
   localparam int BC    = 2;
   localparam int FRAME = N * RD;

   logic clk, reset_n, load;
   logic [4*N-1:0] value_in;
   logic [N-1:0] dp_in, digit_en;
   logic load_ack, frame_start, dp;
   logic [N-1:0] an;
   logic [6:0] seg;
   seg7_pkg::state_e dbg_state;

   int checks = 0;
   int failures = 0;

   // Model: displayed word, pending word, edges counted since reset release.
   logic [15:0] m_val, p_val;
   logic [3:0] m_dp, m_en, p_dp, p_en;
   bit p_valid, ack_exp;
   int e;

   logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seg7_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .value_in    (value_in),
      .dp_in       (dp_in),
      .digit_en    (digit_en),
      .load        (load),
      .load_ack    (load_ack),
      .frame_start (frame_start),
      .an          (an),
      .seg         (seg),
      .dp          (dp),
      .dbg_state   (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_val = 16'h0; m_dp = 4'h0; m_en = 4'hF;
      p_valid = 1'b0; ack_exp = 1'b0; e = 0;
   endtask

   task automatic check(input string tag);
      logic [14:0] exp_v, obs_v;
      logic [3:0] exp_an, nib;
      logic [6:0] exp_seg;
      logic exp_dp;
      int c, dv, dg;
      bit blank, lzd, shown;
      if (!reset_n || e == 0) begin
         exp_v = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b0};
      end else begin
         c = e - 1;
         dv = c % RD;
         dg = (c / RD) % N;
         blank = dv < BC;
         nib = m_val[4*dg +: 4];
         lzd = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
         lzd = (dg > 0) && ((m_val >> (4*dg)) == 16'h0);
`endif
         shown = m_en[dg] && !lzd;
         exp_an = 4'hF;
         if (!blank && shown) exp_an[dg] = 1'b0;
         exp_seg = blank ? 7'h7F : hex_tab[nib];
         exp_dp = blank ? 1'b1 : !(m_dp[dg] && !lzd);
         exp_v = {exp_an, exp_seg, exp_dp, ack_exp, (c % FRAME) == 0, !blank};
      end
      obs_v = {an, seg, dp, load_ack, frame_start, dbg_state == seg7_pkg::DRIVE};
      checks++;
      assert (obs_v === exp_v) else begin
         failures++;
         $error("FAIL %s edge=%0d obs{an,seg,dp,ack,fs,st}=%h exp=%h", tag, e, obs_v, exp_v);
      end
   endtask

   // One clock: update the model at the rising edge, check at the falling edge.
   task automatic tick(input string tag);
      @(posedge clk);
      if (reset_n) begin
         e++;
         ack_exp = 1'b0;
         if (e >= 2 && ((e - 2) % FRAME) == FRAME - 1 && p_valid) begin
            m_val = p_val; m_dp = p_dp; m_en = p_en;
            p_valid = 1'b0;
            ack_exp = 1'b1;
         end
         if (load) begin
            p_val = value_in; p_dp = dp_in; p_en = digit_en;
            p_valid = 1'b1;
         end
      end
      @(negedge clk);
      check(tag);
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) tick(tag);
   endtask

   // Advance until the cycle about to be sampled at the next edge is frame position pos.
   task automatic run_to(input int pos, input string tag);
      while (((e - 1) % FRAME) != pos) tick(tag);
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] en,
                          input string tag);
      value_in = v; dp_in = d; digit_en = en; load = 1'b1;
      tick(tag);
      load = 1'b0;
      value_in = 16'($urandom); dp_in = 4'($urandom); digit_en = 4'($urandom);
   endtask

   initial begin
      reset_n = 1'b0; load = 1'b0;
      value_in = '0; dp_in = '0; digit_en = '0;
      model_reset();
      run(3, "reset");
      reset_n = 1'b1;
      run(2 * FRAME, "idle");

      run_to(10, "pre_12af");
      do_load(16'h12AF, 4'b0100, 4'hF, "load_12af");
      run(2 * FRAME, "show_12af");

      run_to(5, "pre_two");
      do_load(16'h1111, 4'h0, 4'hF, "load_1111");
      run_to(15, "mid_two");
      do_load(16'h2222, 4'h1, 4'hF, "load_2222");
      run(2 * FRAME, "show_2222");

      run_to(4, "pre_3333");
      do_load(16'h3333, 4'h2, 4'hF, "load_3333");
      run_to(31, "wait_edge");
      do_load(16'h4567, 4'h8, 4'hF, "load_on_edge");
      run(2 * FRAME, "after_edge");

      run_to(7, "pre_en");
      do_load(16'($urandom), 4'($urandom), 4'b0101, "load_en0101");
      run(2 * FRAME, "en0101");
      do_load(16'h0007, 4'b0010, 4'hF, "load_0007");
      run(2 * FRAME, "show_0007");

      for (int i = 0; i < 40; i++) begin
         run($urandom_range(0, 40), "rand_gap");
         do_load(16'($urandom), 4'($urandom), 4'($urandom), "rand_load");
      end
      run(2 * FRAME, "rand_tail");

      run_to(12, "pre_rst");
      do_load(16'h9876, 4'hF, 4'hF, "load_before_rst");
      run_to(20, "drive_rst");
      #2 reset_n = 1'b0;
      model_reset();
      #1 check("reset_mid");
      run(3, "reset_hold");
      reset_n = 1'b1;
      run(2 * FRAME, "after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
